// File: rtl/pslip_rr_arb.sv
// pSLIP round-robin arbiter with grant/accept handshake.
// Pointer moves only on accept; optional locked grant.
module pslip_rr_arb #(
  parameter int N = 4,
  parameter bit LOCK = 1'b0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld,
  output logic [IW-1:0] ptr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] pk_idle;
  logic [IW-1:0] pk_acc;
  logic          any_req;
  logic          own_req;

  // Lowest requester at or above p, else lowest overall.
  function automatic logic [IW-1:0] pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] p
  );
    logic [IW-1:0] w;
    logic          lo_hit;
    logic          hi_hit;
    w      = '0;
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r[i] && !lo_hit) begin
        w      = IW'(i);
        lo_hit = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (r[i] && !hi_hit && i >= int'(p)) begin
        w      = IW'(i);
        hi_hit = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [N-1:0] onehot(
    input logic [IW-1:0] i
  );
    return N'(1) << i;
  endfunction

  // Explicit wrap keeps non-power-of-two N correct.
  assign nxt_ptr = (idx_q == IW'(N - 1)) ? '0
                 : idx_q + IW'(1);
  assign pk_idle = pick(req, ptr_q);
  assign pk_acc  = pick(req, nxt_ptr);
  assign any_req = |req;
  assign own_req = req[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && any_req) begin
          state_d = S_OFFER;
          idx_d   = pk_idle;
          gnt_d   = onehot(pk_idle);
          vld_d   = 1'b1;
        end
      end
      S_OFFER: begin
        if (accept) begin
          ptr_d = nxt_ptr;
          if (!LOCK) begin
            if (en && any_req) begin
              idx_d = pk_acc;
              gnt_d = onehot(pk_acc);
            end else begin
              state_d = S_IDLE;
              gnt_d   = '0;
              vld_d   = 1'b0;
            end
          end else if (own_req) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
          end
        end else if (!own_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (!own_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_pslip_rr_arb.sv
// Bench for pslip_rr_arb: three configurations against
// a rotation-based reference model, plus directed cases.
module tb_pslip_rr_arb;

  typedef struct packed {
    int st;
    int idx;
    int ptr;
  } mdl_t;

  localparam mdl_t RST = '{st: 0, idx: 0, ptr: 0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en4 = 0, acc4 = 0;
  logic [7:0] req4 = '0;
  logic       enl = 0, accl = 0;
  logic [7:0] reql = '0;
  logic       en5 = 0, acc5 = 0;
  logic [7:0] req5 = '0;

  logic [3:0] g4, gl;
  logic [4:0] g5;
  logic [1:0] i4, il, p4, pl;
  logic [2:0] i5, p5;
  logic       v4, vl, v5;

  mdl_t m4 = RST, ml = RST, m5 = RST;

  int n_chk = 0;
  int n_fail = 0;

  pslip_rr_arb #(.N(4), .LOCK(1'b0)) u4 (
    .clk(clk), .rst(rst), .en(en4),
    .req(req4[3:0]), .accept(acc4),
    .gnt(g4), .gnt_idx(i4), .gnt_vld(v4), .ptr(p4)
  );

  pslip_rr_arb #(.N(4), .LOCK(1'b1)) ul (
    .clk(clk), .rst(rst), .en(enl),
    .req(reql[3:0]), .accept(accl),
    .gnt(gl), .gnt_idx(il), .gnt_vld(vl), .ptr(pl)
  );

  pslip_rr_arb #(.N(5), .LOCK(1'b0)) u5 (
    .clk(clk), .rst(rst), .en(en5),
    .req(req5[4:0]), .accept(acc5),
    .gnt(g5), .gnt_idx(i5), .gnt_vld(v5), .ptr(p5)
  );

  always #5 clk = ~clk;

  // Scan n positions starting at p, wrapping.
  function automatic int pick(
    input logic [7:0] r, input int p, input int n
  );
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return 0;
  endfunction

  function automatic mdl_t mstep(
    input mdl_t m, input int n, input bit lock,
    input bit en, input logic [7:0] req, input bit acc
  );
    mdl_t r;
    int nx;
    logic [7:0] mask;
    mask = 8'((1 << n) - 1);
    req  = req & mask;
    r    = m;
    nx   = (m.idx + 1) % n;
    if (m.st == 0) begin
      if (en && req != 0) begin
        r.idx = pick(req, m.ptr, n);
        r.st  = 1;
      end
    end else if (m.st == 1) begin
      if (acc) begin
        r.ptr = nx;
        if (!lock) begin
          if (en && req != 0) r.idx = pick(req, nx, n);
          else r.st = 0;
        end else begin
          r.st = req[m.idx] ? 2 : 0;
        end
      end else if (!req[m.idx]) begin
        r.st = 0;
      end
    end else begin
      if (!req[m.idx]) r.st = 0;
    end
    return r;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cmp(
    input string nm, input mdl_t m,
    input logic [7:0] g, input logic [7:0] gi,
    input logic v, input logic [7:0] p
  );
    logic [7:0] eg;
    eg = (m.st != 0) ? 8'(1 << m.idx) : 8'h0;
    chk({nm, ".vld"}, 32'(v), 32'(m.st != 0));
    chk({nm, ".gnt"}, 32'(g), 32'(eg));
    chk({nm, ".idx"}, 32'(gi), 32'(m.idx));
    chk({nm, ".ptr"}, 32'(p), 32'(m.ptr));
  endtask

  always @(negedge clk) begin
    cmp("u4", m4, {4'b0, g4}, {6'b0, i4}, v4, {6'b0, p4});
    cmp("ul", ml, {4'b0, gl}, {6'b0, il}, vl, {6'b0, pl});
    cmp("u5", m5, {3'b0, g5}, {5'b0, i5}, v5, {5'b0, p5});
  end

  task automatic step();
    mdl_t n4, nl, n5;
    if (rst) begin
      n4 = RST; nl = RST; n5 = RST;
    end else begin
      n4 = mstep(m4, 4, 1'b0, en4, req4, acc4);
      nl = mstep(ml, 4, 1'b1, enl, reql, accl);
      n5 = mstep(m5, 5, 1'b0, en5, req5, acc5);
    end
    @(posedge clk);
    m4 = n4; ml = nl; m5 = n5;
    #1;
  endtask

  task automatic quiet();
    en4 = 0; acc4 = 0; req4 = '0;
    enl = 0; accl = 0; reql = '0;
    en5 = 0; acc5 = 0; req5 = '0;
  endtask

  initial begin
    chk("pick_a", pick(8'b1010, 0, 4), 1);
    chk("pick_b", pick(8'b10001, 4, 5), 4);
    chk("pick_c", pick(8'b0001, 2, 4), 0);

    quiet();
    step(); step();
    rst = 0;
    step();
    chk("rst_vld", 32'(v4), 0);
    chk("rst_ptr", 32'(p4), 0);

    // N=4 LOCK=0 back-to-back
    en4 = 1; req4 = 8'b1010; step();
    chk("d4_g1", 32'(g4), 32'b0010);
    chk("d4_i1", 32'(i4), 1);
    acc4 = 1; step();
    chk("d4_p2", 32'(p4), 2);
    chk("d4_g2", 32'(g4), 32'b1000);
    chk("d4_i2", 32'(i4), 3);
    step();
    chk("d4_p3", 32'(p4), 0);
    chk("d4_g3", 32'(g4), 32'b0010);
    en4 = 0; step();
    chk("d4_p4", 32'(p4), 2);
    chk("d4_v4", 32'(v4), 0);

    // wrap without accept, then withdrawal
    acc4 = 0; en4 = 1; req4 = 8'b0001; step();
    chk("wr_g", 32'(g4), 32'b0001);
    req4 = 8'b0000; step();
    chk("wd_g", 32'(g4), 0);
    chk("wd_p", 32'(p4), 2);

    // accept and withdrawal together
    req4 = 8'b0010; step();
    chk("aw_i", 32'(i4), 1);
    req4 = 8'b0000; acc4 = 1; step();
    chk("aw_p", 32'(p4), 2);
    chk("aw_v", 32'(v4), 0);

    // LOCK=1 hold
    quiet();
    enl = 1; reql = 8'b0100; step();
    chk("lk_g", 32'(gl), 32'b0100);
    reql = 8'b1111; accl = 1; step();
    chk("lk_p", 32'(pl), 3);
    for (int k = 0; k < 3; k++) begin
      accl = ~accl; step();
      chk("lk_hold", 32'(gl), 32'b0100);
    end
    reql = 8'b1011; accl = 0; step();
    chk("lk_rel", 32'(gl), 0);
    chk("lk_rp", 32'(pl), 3);

    // N=5 wrap
    quiet();
    en5 = 1; req5 = 8'b01000; step();
    acc5 = 1; en5 = 0; step();
    chk("n5_p4", 32'(p5), 4);
    acc5 = 0; en5 = 1; req5 = 8'b10001; step();
    chk("n5_g", 32'(g5), 32'b10000);
    acc5 = 1; step();
    chk("n5_p0", 32'(p5), 0);
    chk("n5_g0", 32'(g5), 32'b00001);

    // async reset mid-OFFER
    quiet();
    en4 = 1; req4 = 8'b0001; step();
    acc4 = 1; en4 = 0; step();
    acc4 = 0; en4 = 1; req4 = 8'b0100; step();
    chk("ar_g", 32'(g4), 32'b0100);
    chk("ar_p", 32'(p4), 1);
    #1 rst = 1;
    m4 = RST; ml = RST; m5 = RST;
    #1;
    chk("ar_rg", 32'(g4), 0);
    chk("ar_rv", 32'(v4), 0);
    chk("ar_ri", 32'(i4), 0);
    chk("ar_rp", 32'(p4), 0);
    step();
    rst = 0;

    // randomized run
    for (int c = 0; c < 3000; c++) begin
      en4 = ($urandom_range(3) != 0);
      enl = ($urandom_range(3) != 0);
      en5 = ($urandom_range(3) != 0);
      req4 = 8'($urandom_range(15));
      reql = 8'($urandom_range(15));
      req5 = 8'($urandom_range(31));
      acc4 = 1'($urandom_range(1));
      accl = 1'($urandom_range(1));
      acc5 = 1'($urandom_range(1));
      if (!rst && $urandom_range(199) == 0) begin
        rst = 1;
        m4 = RST; ml = RST; m5 = RST;
      end else begin
        rst = 0;
      end
      step();
    end
    rst = 0;
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
